// File: rtl/sprite_line_fetch.sv
// Purpose: prefetches one sprite row per display line into a ping-pong line buffer and serves it to the pixel path.
// Latency: 42 cycles from line_start to done for a visible row (1 cycle for a row outside the sprite); pixel path 1 cycle.
// Backpressure: none; line_start arriving during FETCH/DRAIN is dropped, and the RAM returns data one cycle after each address.
//
// Ports:
//   Clk, Reset          clock; synchronous active-high reset
//   line_start          one-cycle request to prefetch the row for next_y
//   next_y, spr_x/y     display row and sprite origin, sampled with line_start
//   mirror              horizontal flip, sampled with line_start
//   read_address        registered sprite RAM address (holds outside FETCH)
//   ram_data            RAM word for the address presented in the previous cycle
//   busy, done          fetch in progress / one-cycle completion pulse
//   draw_x              current display column
//   pixel_idx, pixel_on palette index and opacity for the previous cycle's draw_x
module sprite_line_fetch #(
  parameter int SPR_W  = 40,
  parameter int SPR_H  = 60,
  parameter int DATA_W = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              line_start,
  input  logic [9:0]        next_y,
  input  logic [9:0]        spr_x,
  input  logic [9:0]        spr_y,
  input  logic              mirror,
  input  logic [9:0]        draw_x,
  output logic [18:0]       read_address,
  input  logic [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] pixel_idx,
  output logic              pixel_on
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t state, state_n;

  logic              accept;     // visible row requested in IDLE
  logic              reject;     // row outside the sprite requested in IDLE
  logic              finish;     // last word is being captured this cycle

  logic [10:0]       row_s;
  logic              row_ok;
  logic [18:0]       base_new;
  logic [18:0]       base_q;
  logic              mirror_q;

  logic [CW-1:0]     col_q;      // column whose address is on read_address
  logic [CW-1:0]     col_nxt;
  logic [CW-1:0]     col_eff_nxt;
  logic              col_last;

  // Capture pipeline: the RAM word for col_q arrives one cycle later.
  logic              cap_vld;
  logic [CW-1:0]     cap_col;

  // Ping-pong line buffer: act_bank is displayed, the other one is filled.
  logic              act_bank;
  logic              pend_bank;
  logic [1:0]        bank_vld;
  logic [9:0]        bank_x [2];
  logic [DATA_W-1:0] bank [2][SPR_W];

  logic [10:0]       off;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;

  // Row relative to the sprite top in 11-bit two's complement so that a
  // display row above the sprite comes out negative instead of wrapping.
  assign row_s    = {1'b0, next_y} - {1'b0, spr_y};
  assign row_ok   = !row_s[10] && (row_s < 11'(SPR_H));
  assign base_new = 19'(row_s[9:0]) * 19'(SPR_W);

  assign col_last    = (col_q == COL_LAST);
  assign col_nxt     = col_q + CW'(1);
  // Mirroring only reorders the RAM addresses; the buffer is always written
  // in issue order, so the display side never needs to know about the flip.
  assign col_eff_nxt = mirror_q ? (COL_LAST - col_nxt) : col_nxt;

  assign pend_bank = ~act_bank;
  assign busy      = (state != IDLE);
  assign finish    = (state == DRAIN);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state)
      IDLE: begin
        if (line_start) begin
          if (row_ok) begin
            accept  = 1'b1;
            state_n = FETCH;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      FETCH: begin
        if (col_last) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------ fetch datapath
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address <= '0;
      done         <= 1'b0;
      base_q       <= '0;
      mirror_q     <= 1'b0;
      col_q        <= '0;
      cap_vld      <= 1'b0;
      cap_col      <= '0;
      act_bank     <= 1'b0;
      bank_vld     <= 2'b00;
    end else begin
      done    <= reject | finish;
      cap_vld <= (state == FETCH);
      cap_col <= col_q;

      if (accept) begin
        base_q               <= base_new;
        mirror_q             <= mirror;
        col_q                <= '0;
        read_address         <= base_new + (mirror ? 19'(SPR_W - 1) : 19'd0);
        bank_x[pend_bank]    <= spr_x;
        bank_vld[pend_bank]  <= 1'b0;
      end

      // An off-sprite row still completes a line: swap in an invalid bank
      // so the whole display line stays transparent.
      if (reject) begin
        bank_x[pend_bank]   <= spr_x;
        bank_vld[pend_bank] <= 1'b0;
        act_bank            <= pend_bank;
      end

      if ((state == FETCH) && !col_last) begin
        col_q        <= col_nxt;
        read_address <= base_q + 19'(col_eff_nxt);
      end

      if (finish) begin
        bank_vld[pend_bank] <= 1'b1;
        act_bank            <= pend_bank;
      end
    end
  end

  // Buffer storage carries no reset; the valid flags gate every read.
  always_ff @(posedge Clk) begin
    if (cap_vld) begin
      bank[pend_bank][cap_col] <= ram_data;
    end
  end

  // ------------------------------------------------------- display path
  // 11-bit difference: columns left of the sprite are negative and columns
  // past the right edge stay large, so nothing wraps onto column 0.
  assign off      = {1'b0, draw_x} - {1'b0, bank_x[act_bank]};
  assign in_range = bank_vld[act_bank] && !off[10] && (off < 11'(SPR_W));
  assign rd_word  = bank[act_bank][off[CW-1:0]];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pixel_idx <= '0;
      pixel_on  <= 1'b0;
    end else begin
      pixel_idx <= in_range ? rd_word : '0;
      pixel_on  <= in_range && (rd_word != '0);
    end
  end

endmodule
